fifo_vr: RTL and testbench

- Synchronous valid/ready FIFO of WIDTH-bit words, DEPTH entries.
- Standard buffering stage placed upstream of any consumer that carries WIDTH/DEPTH parameter constraints. It absorbs producer bursts and back-pressure.
- Parameter constraints are checked at elaboration with a single PARAMCHECK_ALLGOOD conjunction.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/ptr_mod.sv | 36 +++
 rtl/fifo_vr.sv | 131 +++++++++++++
 tb/tb_fifo_vr.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_vr buffering stage.
package fifo_pkg;

  localparam int unsigned MIN_DEPTH = 2;
  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned MAX_WIDTH = 21;

  // Modulo increment with an explicit wrap, so depth need not be a power of two.
  function automatic int unsigned incrWrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ptr_mod.sv
// Wrap-around pointer register: counts 0..DEPTH-1 and returns to 0.
module ptr_mod
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned PTR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_incr,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Advance only on a clock-enabled increment request.
  always_comb begin
    ptr_d = ptr_q;
    if (i_cg && i_incr) begin
      ptr_d = PTR_W'(incrWrap(32'(ptr_q), DEPTH));
    end
  end

  // Pointer register; reset overrides the clock gate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_vr.sv
// Synchronous valid/ready FIFO, WIDTH-bit words, DEPTH entries (any depth 2..64).
// Optional high-water mark tracking is built when FIFO_VR_HIGHWATER_EN is defined;
// otherwise o_highWater reads 0 and i_hwClear is ignored.
module fifo_vr
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [WIDTH-1:0]           i_in_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_out_data,
  output logic [$clog2(DEPTH+1)-1:0] o_nEntries,
  input  logic                       i_hwClear,
  output logic [$clog2(DEPTH+1)-1:0] o_highWater
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // Guard keeps widths legal long enough for the parameter check to report.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam bit PARAMCHECK_ALLGOOD = &{(0 < WIDTH), (WIDTH <= MAX_WIDTH),
                                        (MIN_DEPTH <= DEPTH), (DEPTH <= MAX_DEPTH)};

  if (!PARAMCHECK_ALLGOOD) begin : g_param_check
    $error("fifo_vr: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
    $info("fifo_vr: legal WIDTH 1..%0d, DEPTH %0d..%0d", MAX_WIDTH, MIN_DEPTH, MAX_DEPTH);
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] n_entries_q, n_entries_d;
  logic             push, pop;

  assign o_in_ready  = (n_entries_q != CNT_W'(DEPTH));
  assign o_out_valid = (n_entries_q != '0);
  assign o_out_data  = mem[rd_ptr];
  assign o_nEntries  = n_entries_q;

  assign push = i_in_valid & o_in_ready & i_cg;
  assign pop  = o_out_valid & i_out_ready & i_cg;

  ptr_mod #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cg   (i_cg),
    .i_incr (push),
    .o_ptr  (wr_ptr)
  );

  ptr_mod #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cg   (i_cg),
    .i_incr (pop),
    .o_ptr  (rd_ptr)
  );

  // Storage write; contents are never reset, only pointers and count are.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_in_data;
    end
  end

  // Occupancy next-state: push and pop together leave the count unchanged.
  always_comb begin
    n_entries_d = n_entries_q;
    case ({push, pop})
      2'b10:   n_entries_d = n_entries_q + CNT_W'(1);
      2'b01:   n_entries_d = n_entries_q - CNT_W'(1);
      default: n_entries_d = n_entries_q;
    endcase
  end

  // Occupancy register; reset overrides the clock gate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_entries_q <= '0;
    end else begin
      n_entries_q <= n_entries_d;
    end
  end

`ifdef FIFO_VR_HIGHWATER_EN
  logic [CNT_W-1:0] high_water_q, high_water_d;

  // Track peak occupancy; a clear restarts tracking from the upcoming count.
  always_comb begin
    high_water_d = high_water_q;
    if (i_cg) begin
      if (i_hwClear) begin
        high_water_d = n_entries_d;
      end else if (n_entries_d > high_water_q) begin
        high_water_d = n_entries_d;
      end
    end
  end

  // High-water register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      high_water_q <= '0;
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign o_highWater = high_water_q;
`else
  logic unused_hw_clear;
  assign unused_hw_clear = i_hwClear;
  assign o_highWater     = '0;
`endif

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
                                   n_entries_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fifo_vr.sv
// Directed self-checking bench for fifo_vr (WIDTH=5, DEPTH=10).
module tb_fifo_vr;

  logic       clk;
  logic       rst;
  logic       cg;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [3:0] n_entries;
  logic       hw_clear;
  logic [3:0] high_water;

  int n_checks;
  int n_fail;
  logic [4:0] q[$];

  fifo_vr #(
    .WIDTH (5),
    .DEPTH (10)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cg        (cg),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_nEntries  (n_entries),
    .i_hwClear   (hw_clear),
    .o_highWater (high_water)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push n words starting at base, recording them in the model.
  task automatic push_words(input int n, input logic [4:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 5'(i);
      step();
      q.push_back(base + 5'(i));
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cg = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hw_clear = 1'b0; in_data = '0;
    step();
    step();
    rst = 1'b0;
    q.delete();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (n_entries !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", n_entries);
    end
    n_checks++;
    if (high_water !== 4'd0) begin
      n_fail++; $display("FAIL reset_high_water: got %0d want 0", high_water);
    end
  endtask

  task automatic test_fill_drain();
    push_words(10, 5'h01);
    n_checks++;
    if (n_entries !== 4'd10) begin
      n_fail++; $display("FAIL full_count: got %0d want 10", n_entries);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    // 11th push must be refused
    in_valid = 1'b1;
    in_data  = 5'h1F;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (n_entries !== 4'd10) begin
      n_fail++; $display("FAIL overflow_refused: got %0d want 10", n_entries);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'(i)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, 5'(i));
      end
      step();
    end
    out_ready = 1'b0;
    q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || n_entries !== 4'd0) begin
      n_fail++; $display("FAIL drained_empty: got valid=%b count=%0d want 0/0", out_valid, n_entries);
    end
  endtask

  task automatic test_stream();
    logic [4:0] nxt;
    push_words(3, 5'h10);
    nxt = 5'h13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      in_data = nxt;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== q[0] || n_entries !== 4'd3) begin
        n_fail++;
        $display("FAIL stream[%0d]: got valid=%b data=%h count=%0d want 1/%h/3",
                 c, out_valid, out_data, n_entries, q[0]);
      end
      step();
      void'(q.pop_front());
      q.push_back(nxt);
      nxt = nxt + 5'd1;
    end
    in_valid = 1'b0;
    while (q.size() > 0) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== q[0]) begin
        n_fail++;
        $display("FAIL stream_tail: got valid=%b data=%h want 1/%h", out_valid, out_data, q[0]);
      end
      step();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    n_checks++;
    if (n_entries !== 4'd0) begin
      n_fail++; $display("FAIL stream_empty: got %0d want 0", n_entries);
    end
  endtask

  task automatic test_full_pop();
    push_words(10, 5'h15);
    in_valid  = 1'b1;
    in_data   = 5'h0E;
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 5'h15) begin
      n_fail++;
      $display("FAIL full_pop_pre: got ready=%b data=%h want 0/15", in_ready, out_data);
    end
    step();
    void'(q.pop_front());
    n_checks++;
    if (n_entries !== 4'd9 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_refused: got count=%0d ready=%b want 9/1", n_entries, in_ready);
    end
    out_ready = 1'b0;
    step();
    q.push_back(5'h0E);
    in_valid = 1'b0;
    n_checks++;
    if (n_entries !== 4'd10) begin
      n_fail++; $display("FAIL full_pop_retry: got %0d want 10", n_entries);
    end
    out_ready = 1'b1;
    while (q.size() > 0) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== q[0]) begin
        n_fail++;
        $display("FAIL full_pop_order: got valid=%b data=%h want 1/%h", out_valid, out_data, q[0]);
      end
      step();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_empty_push();
    in_valid  = 1'b1;
    in_data   = 5'h07;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_pre: got valid=%b want 0", out_valid);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || n_entries !== 4'd1 || out_data !== 5'h07) begin
      n_fail++;
      $display("FAIL empty_push: got valid=%b count=%0d data=%h want 1/1/07",
               out_valid, n_entries, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_cg_and_reset();
    push_words(6, 5'h08);
    cg        = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h1B;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (n_entries !== 4'd6 || out_data !== 5'h08) begin
        n_fail++;
        $display("FAIL cg_hold[%0d]: got count=%0d data=%h want 6/08", c, n_entries, out_data);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // reset must act even with the clock gate closed
    rst = 1'b1;
    step();
    rst = 1'b0;
    cg  = 1'b1;
    q.delete();
    n_checks++;
    if (n_entries !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got count=%0d valid=%b ready=%b want 0/0/1",
               n_entries, out_valid, in_ready);
    end
  endtask

  task automatic test_highwater();
    push_words(7, 5'h02);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    out_ready = 1'b0;
    q.delete();
`ifdef FIFO_VR_HIGHWATER_EN
    n_checks++;
    if (high_water !== 4'd7) begin
      n_fail++; $display("FAIL high_water_peak: got %0d want 7", high_water);
    end
    push_words(2, 5'h03);
    hw_clear = 1'b1;
    step();
    hw_clear = 1'b0;
    n_checks++;
    if (high_water !== 4'd2) begin
      n_fail++; $display("FAIL high_water_clear: got %0d want 2", high_water);
    end
`else
    n_checks++;
    if (high_water !== 4'd0) begin
      n_fail++; $display("FAIL high_water_off: got %0d want 0", high_water);
    end
    push_words(2, 5'h03);
    hw_clear = 1'b1;
    step();
    hw_clear = 1'b0;
    n_checks++;
    if (high_water !== 4'd0 || n_entries !== 4'd2) begin
      n_fail++;
      $display("FAIL high_water_off_clear: got hw=%0d count=%0d want 0/2", high_water, n_entries);
    end
`endif
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_pop();
    test_empty_push();
    test_cg_and_reset();
    test_highwater();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
